// File: rtl/microcontroller.sv
// Coin-operated washing-machine sequencer: payment, lid interlock, timed wash
// phases, pause/cancel handling, spin rebalancing and motor-fault lockout.
module microcontroller #(
  parameter int PHASE_CYCLES = 4,
  parameter int MAX_REBAL    = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sig_Lid_Closed,
  input  logic       sig_Coin,
  input  logic       sig_Cancel,
  input  logic       sig_Time_Out,
  input  logic       sig_Out_Of_Balance,
  input  logic       sig_Motor_Failure,
  output logic [3:0] state
);

  localparam logic [3:0] IDLE         = 4'd0;
  localparam logic [3:0] PAID         = 4'd1;
  localparam logic [3:0] SOAK         = 4'd2;
  localparam logic [3:0] WASH         = 4'd3;
  localparam logic [3:0] DRAIN1       = 4'd4;
  localparam logic [3:0] RINSE        = 4'd5;
  localparam logic [3:0] DRAIN2       = 4'd6;
  localparam logic [3:0] SPIN         = 4'd7;
  localparam logic [3:0] DONE         = 4'd8;
  localparam logic [3:0] PAUSED       = 4'd9;
  localparam logic [3:0] REBALANCE    = 4'd10;
  localparam logic [3:0] CANCEL_DRAIN = 4'd11;
  localparam logic [3:0] FAULT        = 4'd12;

  localparam int TW = $clog2(PHASE_CYCLES + 1) + 1;
  localparam int CW = $clog2(MAX_REBAL + 1) + 1;
  localparam logic [TW-1:0] TMAX = {TW{1'b1}};

  logic [3:0]    state_reg, state_next;
  logic [3:0]    saved_state_reg, saved_state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [TW-1:0] saved_timer_reg, saved_timer_next;
  logic [CW-1:0] rebal_reg, rebal_next;
  logic [TW-1:0] timer_inc;
  logic          timed, phase_done, motor_state, restore;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      saved_state_reg <= IDLE;
      timer_reg       <= '0;
      saved_timer_reg <= '0;
      rebal_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      saved_state_reg <= saved_state_next;
      timer_reg       <= timer_next;
      saved_timer_reg <= saved_timer_next;
      rebal_reg       <= rebal_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    saved_state_next = saved_state_reg;
    saved_timer_next = saved_timer_reg;
    rebal_next       = rebal_reg;
    restore          = 1'b0;
    timed       = ((state_reg >= SOAK) && (state_reg <= SPIN)) ||
                  (state_reg == REBALANCE) || (state_reg == CANCEL_DRAIN);
    motor_state = (state_reg == WASH) || (state_reg == RINSE) ||
                  (state_reg == SPIN) || (state_reg == REBALANCE);
    phase_done  = (timer_reg >= TW'(PHASE_CYCLES - 1)) || sig_Time_Out;
    timer_inc   = (timer_reg == TMAX) ? timer_reg : timer_reg + TW'(1);
    timer_next  = timed ? timer_inc : timer_reg;

    case (state_reg)
      IDLE: begin
        rebal_next = '0;
        if (sig_Coin) state_next = PAID;
      end
      PAID: begin
        if (sig_Cancel)          state_next = IDLE;
        else if (sig_Lid_Closed) state_next = SOAK;
      end
      SOAK, WASH, DRAIN1, RINSE, DRAIN2, SPIN, REBALANCE: begin
        if (motor_state && sig_Motor_Failure) begin
          state_next = FAULT;
        end else if (sig_Cancel) begin
          state_next = CANCEL_DRAIN;
        end else if (!sig_Lid_Closed) begin
          // The cycle in which the lid dropped counts as elapsed phase time.
          state_next       = PAUSED;
          saved_state_next = state_reg;
          saved_timer_next = timer_inc;
        end else if ((state_reg == SPIN) && sig_Out_Of_Balance) begin
          if (rebal_reg >= CW'(MAX_REBAL)) begin
            state_next = FAULT;
          end else begin
            state_next = REBALANCE;
            rebal_next = rebal_reg + CW'(1);
          end
        end else if (phase_done) begin
          case (state_reg)
            SOAK:    state_next = WASH;
            WASH:    state_next = DRAIN1;
            DRAIN1:  state_next = RINSE;
            RINSE:   state_next = DRAIN2;
            DRAIN2:  state_next = SPIN;
            SPIN:    state_next = DONE;
            default: state_next = SPIN;
          endcase
        end
      end
      PAUSED: begin
        if (sig_Cancel) begin
          state_next = CANCEL_DRAIN;
        end else if (sig_Lid_Closed) begin
          state_next = saved_state_reg;
          restore    = 1'b1;
        end
      end
      CANCEL_DRAIN: begin
        if (phase_done) state_next = DONE;
      end
      DONE: begin
        if (!sig_Lid_Closed) state_next = IDLE;
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (restore)                       timer_next = saved_timer_reg;
    else if (state_next != state_reg)  timer_next = '0;

    if ((state_next == SOAK) && (state_reg != SOAK)) rebal_next = '0;
  end

  always_comb begin
    state = state_reg;
  end

endmodule

// File: tb/tb_microcontroller.sv
// Directed bench for the washing-machine sequencer: walks each scenario edge
// by edge and checks the registered state code against hand-derived values.
module tb_microcontroller;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       sig_Lid_Closed = 1'b0;
  logic       sig_Coin = 1'b0;
  logic       sig_Cancel = 1'b0;
  logic       sig_Time_Out = 1'b0;
  logic       sig_Out_Of_Balance = 1'b0;
  logic       sig_Motor_Failure = 1'b0;
  logic [3:0] state;

  int checks = 0;
  int failures = 0;
  int edge_no = 0;

  microcontroller #(.PHASE_CYCLES(4), .MAX_REBAL(3)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .sig_Lid_Closed(sig_Lid_Closed),
    .sig_Coin(sig_Coin),
    .sig_Cancel(sig_Cancel),
    .sig_Time_Out(sig_Time_Out),
    .sig_Out_Of_Balance(sig_Out_Of_Balance),
    .sig_Motor_Failure(sig_Motor_Failure),
    .state(state)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [3:0] exp);
    checks++;
    assert (state === exp) else begin
      failures++;
      $error("FAIL %s edge=%0d state=%0d expected=%0d", tag, edge_no, state, exp);
    end
    $display("t=%0t %s edge=%0d state=%0d expected=%0d", $time, tag, edge_no, state, exp);
  endtask

  task automatic step(input string tag, input logic [3:0] exp);
    @(posedge clock);
    #1;
    edge_no++;
    chk(tag, exp);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    edge_no = 0;
  endtask

  initial begin
    logic [3:0] exp;

    // Normal run
    do_reset();
    chk("reset_state", 4'd0);
    sig_Coin = 1'b1;
    sig_Lid_Closed = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      if (k == 1)      exp = 4'd1;
      else if (k < 26) exp = 4'(2 + (k - 2) / 4);
      else             exp = 4'd8;
      step("normal_run", exp);
    end
    sig_Lid_Closed = 1'b0;
    sig_Coin = 1'b0;
    step("done_lid_open", 4'd0);

    // Lid open in WASH at timer=1, motor failure ignored while paused
    sig_Coin = 1'b1;
    step("coin", 4'd1);
    sig_Coin = 1'b0;
    sig_Lid_Closed = 1'b1;
    step("to_soak", 4'd2);
    for (int i = 0; i < 3; i++) step("soak", 4'd2);
    step("to_wash", 4'd3);
    step("wash_t1", 4'd3);
    sig_Lid_Closed = 1'b0;
    step("pause_enter", 4'd9);
    sig_Motor_Failure = 1'b1;
    step("pause_motor_ignored", 4'd9);
    sig_Motor_Failure = 1'b0;
    for (int i = 0; i < 3; i++) step("paused", 4'd9);
    sig_Lid_Closed = 1'b1;
    step("resume_wash", 4'd3);
    step("wash_after_resume", 4'd3);
    step("wash_end", 4'd4);
    for (int i = 0; i < 3; i++) step("drain1", 4'd4);
    step("to_rinse", 4'd5);

    // Cancel in RINSE
    sig_Cancel = 1'b1;
    step("cancel_rinse", 4'd11);
    sig_Cancel = 1'b0;
    sig_Lid_Closed = 1'b0;
    for (int i = 0; i < 3; i++) step("cancel_drain", 4'd11);
    sig_Lid_Closed = 1'b1;
    step("cancel_done", 4'd8);
    sig_Coin = 1'b1;
    step("done_ignores_coin", 4'd8);
    sig_Coin = 1'b0;
    sig_Lid_Closed = 1'b0;
    step("done_to_idle", 4'd0);

    // Cancel in PAID beats lid closed
    sig_Coin = 1'b1;
    step("coin2", 4'd1);
    sig_Coin = 1'b0;
    sig_Cancel = 1'b1;
    sig_Lid_Closed = 1'b1;
    step("paid_cancel", 4'd0);
    sig_Cancel = 1'b0;

    // Time-out in IDLE ignored; time-outs fast-forward to SPIN
    sig_Time_Out = 1'b1;
    step("idle_timeout", 4'd0);
    sig_Time_Out = 1'b0;
    sig_Coin = 1'b1;
    step("coin3", 4'd1);
    sig_Coin = 1'b0;
    step("to_soak3", 4'd2);
    sig_Time_Out = 1'b1;
    for (int s = 3; s <= 7; s++) step("timeout_adv", 4'(s));
    sig_Time_Out = 1'b0;

    // Imbalance: three rebalances then FAULT on the fourth
    for (int r = 0; r < 3; r++) begin
      sig_Out_Of_Balance = 1'b1;
      step("rebal_enter", 4'd10);
      sig_Out_Of_Balance = 1'b0;
      for (int i = 0; i < 3; i++) step("rebal", 4'd10);
      step("rebal_to_spin", 4'd7);
    end
    sig_Out_Of_Balance = 1'b1;
    step("rebal_limit_fault", 4'd12);
    sig_Out_Of_Balance = 1'b0;

    // Motor failure in WASH with cancel
    do_reset();
    chk("reset_after_fault", 4'd0);
    sig_Coin = 1'b1;
    step("coin4", 4'd1);
    sig_Coin = 1'b0;
    step("to_soak4", 4'd2);
    sig_Time_Out = 1'b1;
    step("soak_timeout_t0", 4'd3);
    sig_Time_Out = 1'b0;
    sig_Motor_Failure = 1'b1;
    sig_Cancel = 1'b1;
    step("motor_beats_cancel", 4'd12);
    sig_Motor_Failure = 1'b0;
    sig_Lid_Closed = 1'b0;
    sig_Coin = 1'b1;
    sig_Time_Out = 1'b1;
    step("fault_hold1", 4'd12);
    sig_Out_Of_Balance = 1'b1;
    step("fault_hold2", 4'd12);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", 4'd0);
    sig_Cancel = 1'b0;
    sig_Coin = 1'b0;
    sig_Time_Out = 1'b0;
    sig_Out_Of_Balance = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    step("idle_after_reset", 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
